// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller.
// Optional perf counters are enabled with HAZARD_PERF_CNT_EN.
package ex_hazard_ctrl_pkg;

  localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

  localparam int FCNT_W = 3;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic ex;
    logic mem;
  } match_t;

  // The youngest producer wins, so EX beats MEM.
  function automatic fwd_sel_t fwd_pick(
    input match_t m
  );
    fwd_sel_t s;
    s = FWD_NONE;
    priority case (1'b1)
      m.ex:    s = FWD_MEM;
      m.mem:   s = FWD_WB;
      default: s = FWD_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// Perf counter ports exist only with HAZARD_PERF_CNT_EN.
interface ex_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_is_load;
  logic                  ex_branch_taken;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_reg_write;
  logic                  mem_stall;

  logic                  stall_if;
  logic                  stall_id;
  logic                  bubble_ex;
  logic                  flush_if;
  logic                  flush_id;
  logic [1:0]            fwd_a_sel;
  logic [1:0]            fwd_b_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_rd, ex_reg_write,
    output ex_is_load, ex_branch_taken,
    output mem_valid, mem_rd, mem_reg_write,
    output mem_stall,
    input  stall_if, stall_id, bubble_ex,
    input  flush_if, flush_id,
    input  fwd_a_sel, fwd_b_sel,
    input  perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_rd, ex_reg_write,
    input  ex_is_load, ex_branch_taken,
    input  mem_valid, mem_rd, mem_reg_write,
    input  mem_stall,
    output stall_if, stall_id, bubble_ex,
    output flush_if, flush_id,
    output fwd_a_sel, fwd_b_sel,
    output perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_rd, ex_reg_write,
    output ex_is_load, ex_branch_taken,
    output mem_valid, mem_rd, mem_reg_write,
    output mem_stall,
    input  stall_if, stall_id, bubble_ex,
    input  flush_if, flush_id,
    input  fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_rd, ex_reg_write,
    input  ex_is_load, ex_branch_taken,
    input  mem_valid, mem_rd, mem_reg_write,
    input  mem_stall,
    output stall_if, stall_id, bubble_ex,
    output flush_if, flush_id,
    output fwd_a_sel, fwd_b_sel
  );
`endif

endinterface

// File: rtl/ex_hazard_ctrl_match.sv
// RAW comparator for one decode source against EX and MEM.
// Purely combinational; x0 never matches.
module ex_hazard_ctrl_match
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  uses,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output match_t                hit
);

  logic rs_live;
  logic ex_wr;
  logic mem_wr;

  // rd == rs, so a non-zero rs implies a non-zero rd.
  assign rs_live = uses & (|rs);
  assign ex_wr   = ex_valid & ex_reg_write;
  assign mem_wr  = mem_valid & mem_reg_write;

  assign hit.ex  = rs_live & ex_wr
                 & (ex_rd == rs);
  assign hit.mem = rs_live & mem_wr
                 & (mem_rd == rs);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: forwarding, load-use, flush.
// Define HAZARD_PERF_CNT_EN for stall/flush perf counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int BRANCH_PENALTY = 2
) (
  input logic            clk,
  input logic            rst_n,
  ex_hazard_ctrl_if.slave bus
);

  localparam logic [FCNT_W-1:0] FLUSH_LOAD =
    FCNT_W'(BRANCH_PENALTY - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE =
    FCNT_W'(1);

  match_t            m1;
  match_t            m2;
  hazard_state_t     state;
  logic [FCNT_W-1:0] fcnt;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;

  logic in_run;
  logic load_use;
  logic take_br;
  logic lu_bubble;
  logic advance;

  logic s_if;
  logic s_id;
  logic bub;
  logic f_if;
  logic f_id;

  ex_hazard_ctrl_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_rs1 (
    .uses         (bus.id_uses_rs1),
    .rs           (bus.id_rs1),
    .ex_valid     (bus.ex_valid),
    .ex_reg_write (bus.ex_reg_write),
    .ex_rd        (bus.ex_rd),
    .mem_valid    (bus.mem_valid),
    .mem_reg_write(bus.mem_reg_write),
    .mem_rd       (bus.mem_rd),
    .hit          (m1)
  );

  ex_hazard_ctrl_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_rs2 (
    .uses         (bus.id_uses_rs2),
    .rs           (bus.id_rs2),
    .ex_valid     (bus.ex_valid),
    .ex_reg_write (bus.ex_reg_write),
    .ex_rd        (bus.ex_rd),
    .mem_valid    (bus.mem_valid),
    .mem_reg_write(bus.mem_reg_write),
    .mem_rd       (bus.mem_rd),
    .hit          (m2)
  );

  assign in_run   = (state == RUN);
  assign load_use = in_run & bus.ex_is_load
                  & (m1.ex | m2.ex);
  assign take_br  = in_run & bus.ex_valid
                  & bus.ex_branch_taken
                  & ~bus.mem_stall;
  // A taken branch makes the dependent op wrong-path.
  assign lu_bubble = load_use & ~take_br
                   & ~bus.mem_stall;

  always_comb begin
    s_if = 1'b0;
    s_id = 1'b0;
    bub  = 1'b0;
    f_if = 1'b0;
    f_id = 1'b0;
    if (!rst_n) begin
      s_if = 1'b0;
    end else if (bus.mem_stall) begin
      s_if = 1'b1;
      s_id = 1'b1;
    end else if (!in_run) begin
      f_if = 1'b1;
      f_id = 1'b1;
    end else if (take_br) begin
      f_if = 1'b1;
      f_id = 1'b1;
      bub  = 1'b1;
    end else if (lu_bubble) begin
      s_if = 1'b1;
      s_id = 1'b1;
      bub  = 1'b1;
    end
  end

  assign advance = bus.id_valid & ~s_id
                 & ~bus.mem_stall & ~bub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= '0;
    end else if (!bus.mem_stall) begin
      unique case (state)
        RUN: begin
          if (take_br && BRANCH_PENALTY > 1) begin
            state <= FLUSH;
            fcnt  <= FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (fcnt <= FCNT_ONE) begin
            state <= RUN;
            fcnt  <= '0;
          end else begin
            fcnt <= fcnt - FCNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= '0;
        end
      endcase
    end
  end

  // Selects travel with the instruction entering EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= FWD_NONE;
      fwd_b <= FWD_NONE;
    end else if (!bus.mem_stall) begin
      if (advance) begin
        fwd_a <= fwd_pick(m1);
        fwd_b <= fwd_pick(m2);
      end else begin
        fwd_a <= FWD_NONE;
        fwd_b <= FWD_NONE;
      end
    end
  end

  assign bus.stall_if  = s_if;
  assign bus.stall_id  = s_id;
  assign bus.bubble_ex = bub;
  assign bus.flush_if  = f_if;
  assign bus.flush_id  = f_id;
  assign bus.fwd_a_sel = fwd_a;
  assign bus.fwd_b_sel = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_bubble)
        stall_cnt <= stall_cnt + 32'd1;
      if (take_br)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl (BRANCH_PENALTY=2).
// Perf counters checked when HAZARD_PERF_CNT_EN is defined.
module tb_ex_hazard_ctrl;

  typedef struct {
    string      name;
    logic [4:0] ctrl;
    logic [1:0] a;
    logic [1:0] b;
    bit         fa;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.REG_ADDR_W(5)) bus();

  ex_hazard_ctrl #(
    .REG_ADDR_W    (5),
    .BRANCH_PENALTY(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ctrl = {stall_if, stall_id, bubble_ex, flush_if, flush_id}
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.stall_if, bus.stall_id, bus.bubble_ex,
             bus.flush_if, bus.flush_id};
      checks++;
      if (act !== e.ctrl) begin
        errors++;
        $display("FAIL %s ctrl got %b want %b",
                 e.name, act, e.ctrl);
      end
      if (e.fa) begin
        checks++;
        if (bus.fwd_a_sel !== e.a || bus.fwd_b_sel !== e.b) begin
          errors++;
          $display("FAIL %s fwd got a=%0d b=%0d want a=%0d b=%0d",
                   e.name, bus.fwd_a_sel, bus.fwd_b_sel, e.a, e.b);
        end
      end
    end
  end

  task automatic idle();
    bus.id_valid        = 1'b0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_valid        = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_reg_write    = 1'b0;
    bus.ex_is_load      = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_valid       = 1'b0;
    bus.mem_rd          = '0;
    bus.mem_reg_write   = 1'b0;
    bus.mem_stall       = 1'b0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1,
                        input logic [4:0] r2,
                        input logic u1, input logic u2);
    bus.id_valid    = v;
    bus.id_rs1      = r1;
    bus.id_rs2      = r2;
    bus.id_uses_rs1 = u1;
    bus.id_uses_rs2 = u2;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd,
                        input logic w, input logic ld,
                        input logic br);
    bus.ex_valid        = v;
    bus.ex_rd           = rd;
    bus.ex_reg_write    = w;
    bus.ex_is_load      = ld;
    bus.ex_branch_taken = br;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] rd,
                         input logic w);
    bus.mem_valid     = v;
    bus.mem_rd        = rd;
    bus.mem_reg_write = w;
  endtask

  // Queue the expected response for the inputs now applied.
  task automatic expc(input string n, input logic [4:0] c,
                      input logic [1:0] a, input logic [1:0] b,
                      input bit fa);
    exp_t e;
    e.name = n;
    e.ctrl = c;
    e.a    = a;
    e.b    = b;
    e.fa   = fa;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic chk_perf(input string n, input int s,
                          input int f);
    checks++;
    if (bus.perf_stall_cnt !== 32'(s) ||
        bus.perf_flush_cnt !== 32'(f)) begin
      errors++;
      $display("FAIL %s perf got s=%0d f=%0d want s=%0d f=%0d",
               n, bus.perf_stall_cnt, bus.perf_flush_cnt, s, f);
    end
  endtask
`endif

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    expc("reset", 5'b00000, 2'd0, 2'd0, 1'b1);
    rst_n = 1'b1;

    // EX producer -> FWD_MEM on A; mem_stall holds selects
    idle(); set_ex(1, 5, 1, 0, 0); set_id(1, 5, 6, 1, 1);
    expc("ex_fwd_issue", 5'b00000, 2'd0, 2'd0, 1'b0);
    idle(); bus.mem_stall = 1; set_id(1, 0, 0, 1, 1);
    expc("ex_fwd_a", 5'b11000, 2'd1, 2'd0, 1'b1);
    idle();
    expc("mstall_hold", 5'b00000, 2'd1, 2'd0, 1'b1);
    idle();
    expc("no_adv_none", 5'b00000, 2'd0, 2'd0, 1'b1);

    // MEM-only -> WB; EX+MEM -> EX priority; x0 never
    idle(); set_mem(1, 7, 1); set_id(1, 0, 7, 1, 1);
    expc("mem_issue", 5'b00000, 2'd0, 2'd0, 1'b0);
    idle(); set_ex(1, 7, 1, 0, 0); set_mem(1, 7, 1);
    set_id(1, 7, 7, 0, 1);
    expc("mem_fwd_b", 5'b00000, 2'd0, 2'd2, 1'b1);
    idle(); set_ex(1, 0, 1, 0, 0); set_id(1, 0, 0, 1, 1);
    expc("ex_prio_b", 5'b00000, 2'd0, 2'd1, 1'b1);
    idle();
    expc("x0_no_fwd", 5'b00000, 2'd0, 2'd0, 1'b1);

    // Load-use: one bubble then WB forward
    idle(); set_ex(1, 3, 1, 1, 0); set_id(1, 3, 4, 1, 1);
    expc("lu_stall", 5'b11100, 2'd0, 2'd0, 1'b1);
    idle(); set_mem(1, 3, 1); set_id(1, 3, 4, 1, 1);
    expc("lu_release", 5'b00000, 2'd0, 2'd0, 1'b1);
    idle();
    expc("lu_fwd_wb", 5'b00000, 2'd2, 2'd0, 1'b1);
    idle(); set_ex(1, 0, 1, 1, 0); set_id(1, 0, 0, 1, 0);
    expc("lu_x0", 5'b00000, 2'd0, 2'd0, 1'b1);

    // Taken branch: two flush cycles
    idle(); set_ex(1, 0, 0, 0, 1);
    expc("br_take", 5'b00111, 2'd0, 2'd0, 1'b0);
    idle();
    expc("br_flush", 5'b00011, 2'd0, 2'd0, 1'b0);
    idle(); set_ex(1, 3, 1, 1, 1); set_id(1, 3, 0, 1, 0);
    expc("br_over_lu", 5'b00111, 2'd0, 2'd0, 1'b0);
    expc("flush_ignore", 5'b00011, 2'd0, 2'd0, 1'b0);
    idle();
    expc("br_run", 5'b00000, 2'd0, 2'd0, 1'b0);

    // mem_stall inside FLUSH freezes the counter
    idle(); set_ex(1, 0, 0, 0, 1);
    expc("ms_br_take", 5'b00111, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(); bus.mem_stall = 1;
      expc("ms_freeze", 5'b11000, 2'd0, 2'd0, 1'b0);
    end
    idle();
    expc("ms_flush_rest", 5'b00011, 2'd0, 2'd0, 1'b0);
    idle();
    expc("ms_run", 5'b00000, 2'd0, 2'd0, 1'b0);
    idle(); set_ex(1, 0, 0, 0, 1); bus.mem_stall = 1;
    expc("ms_br_block", 5'b11000, 2'd0, 2'd0, 1'b0);
    idle();
    expc("ms_br_none", 5'b00000, 2'd0, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk_perf("perf_pre_rst", 1, 3);
`endif

    // Reset in the middle of FLUSH
    idle(); set_ex(1, 0, 0, 0, 1);
    expc("rst_br_take", 5'b00111, 2'd0, 2'd0, 1'b0);
    idle(); rst_n = 1'b0;
    expc("rst_mid_flush", 5'b00000, 2'd0, 2'd0, 1'b1);
    rst_n = 1'b1; idle();
    expc("rst_no_resid", 5'b00000, 2'd0, 2'd0, 1'b0);

    // Two load-use hazards and one branch after reset
    idle(); set_ex(1, 3, 1, 1, 0); set_id(1, 0, 3, 0, 1);
    expc("lu2_stall", 5'b11100, 2'd0, 2'd0, 1'b0);
    idle();
    expc("lu2_clear", 5'b00000, 2'd0, 2'd0, 1'b0);
    idle(); set_ex(1, 3, 1, 1, 0); set_id(1, 3, 0, 1, 0);
    expc("lu3_stall", 5'b11100, 2'd0, 2'd0, 1'b0);
    idle();
    expc("lu3_clear", 5'b00000, 2'd0, 2'd0, 1'b0);
    idle(); set_ex(1, 0, 0, 0, 1);
    expc("br2_take", 5'b00111, 2'd0, 2'd0, 1'b0);
    idle();
    expc("br2_flush", 5'b00011, 2'd0, 2'd0, 1'b0);
    idle();
    expc("br2_run", 5'b00000, 2'd0, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk_perf("perf_final", 2, 1);
`endif

    for (int i = 0; i < 5 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
